pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the single-cycle core. It replaces the fixed 32-bit PC/branch update.
- Owns the PC register and evaluates sign/zero branch conditions on reg2 data.
- Adds a call/return address stack (RAS), a sticky halt state with resume, and a pipeline stall hold.
- Sits between the ALU (target address) and instruction memory (fetch address = pc_out).

Parameters:
- PC_WIDTH, 32, width of PC and target in bits
- DATA_WIDTH, 32, width of the signed reg2 operand tested by conditional branches
- RAS_DEPTH, 4, number of return-address entries; power of two, >= 2
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and RAS this cycle
- halt_op  input  1  enter HALTED state
- resume  input  1  leave HALTED state
- branch_op  input  3  control-flow opcode (see Behaviour)
- reg2_data  input  DATA_WIDTH  signed condition operand
- target  input  PC_WIDTH  branch/call target (ALU output)
- pc_out  output  PC_WIDTH  current PC, registered
- branch_taken  output  1  registered; 1 for the cycle after a taken redirect
- halted  output  1  registered; 1 while in HALTED
- ras_overflow  output  1  registered one-cycle pulse
- ras_underflow  output  1  registered one-cycle pulse
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset (sync, active-high, highest priority):
  - pc_out=RESET_PC; state=RUN; RAS count=0 and pointer=0.
  - branch_taken, halted, ras_overflow, ras_underflow all 0.
  - Reset mid-call discards RAS contents.
- FSM has two states, RUN and HALTED.
  - RUN -> HALTED when halt_op=1. halt_op wins over stall and branch. PC holds, no RAS change.
  - HALTED -> RUN when resume=1 and halt_op=0. PC holds on that edge; execution restarts from the held PC on the next cycle.
  - In HALTED, all inputs except reset/resume/halt_op are ignored. halted=1 mirrors the state.
- In RUN with stall=1: PC, RAS and flags hold; pulses clear to 0.
- In RUN with stall=0, next PC by branch_op:
  - 000: sequential, pc+1.
  - 001: unconditional jump to target.
  - 011: target if reg2_data<0 (signed), else pc+1.
  - 101: target if reg2_data>0, else pc+1.
  - 111: target if reg2_data==0, else pc+1.
  - 010 CALL: push pc+1 onto RAS; PC=target.
  - 100 RET: PC=popped entry.
  - 110: reserved; treated as sequential.
- branch_taken=1 on the edge where PC loads target or a popped entry; 0 otherwise.
- Arithmetic: pc+1 wraps modulo 2^PC_WIDTH. The comparison uses the full signed DATA_WIDTH operand.
- RAS is circular.
  - Push when count==RAS_DEPTH overwrites the oldest entry; count stays RAS_DEPTH; ras_overflow pulses 1.
  - Pop when count==0: PC=pc+1, ras_underflow pulses 1, branch_taken=0.
- Latency: every decision takes effect at the next rising edge. No combinational input-to-output paths.

Decomposition:
- Shared package pc_seq_pkg holds the branch_op encodings as named constants: BR_NONE, BR_JMP, BR_LTZ, BR_GTZ, BR_EQZ, BR_CALL, BR_RET, BR_RSVD.
- It also holds the FSM state encodings (ST_RUN, ST_HALTED).
- One sub-module: return_addr_stack, parameters RAS_DEPTH/PC_WIDTH.
  - Inputs: push, pop, push_data.
  - Outputs: top_data, count, overflow, underflow.
  - Synchronous reset.

Test Plan:
- Reset, then 5 cycles branch_op=000 -> pc_out 0,1,2,3,4,5; branch_taken=0. Reset asserted at pc=5 -> pc_out=0 next edge.
- pc=10, branch_op=011, reg2_data=-1, target=40 -> pc=40, branch_taken=1. Repeat with reg2_data=0 -> pc=11.
- pc=10, branch_op=111, reg2_data=0, target=7 -> pc=7. Then branch_op=101, reg2_data=0 -> pc=8.
- From pc=2, CALL target=100 -> pc=100, ras_count=1. RET -> pc=3, ras_count=0. Further RET -> pc=4, ras_underflow=1.
- RAS_DEPTH=4, five CALLs from pcs 0,10,20,30,40 (targets = pc+10) -> ras_overflow=1 on the fifth. Five RETs -> returns 41,31,21,11, then underflow.
- Halt and stall:
  - halt_op=1 at pc=6 with branch_op=001 -> pc stays 6, halted=1, holds 3 cycles.
  - resume=1 -> halted=0, pc stays 6, then increments.
  - stall=1 with CALL -> pc and ras_count unchanged.
- PC_WIDTH=4, pc=15, branch_op=000 -> pc=0 (wrap).

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: branch opcodes,
// FSM states and the conditional-branch predicate.
package pc_seq_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JMP  = 3'b001;
  localparam logic [2:0] BR_CALL = 3'b010;
  localparam logic [2:0] BR_LTZ  = 3'b011;
  localparam logic [2:0] BR_RET  = 3'b100;
  localparam logic [2:0] BR_GTZ  = 3'b101;
  localparam logic [2:0] BR_RSVD = 3'b110;
  localparam logic [2:0] BR_EQZ  = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // True when a conditional opcode's test holds for the operand's sign/zero flags.
  function automatic logic cond_met(input logic [2:0] op, input logic is_neg, input logic is_zero);
    logic r;
    r = 1'b0;
    case (op)
      BR_LTZ:  r = is_neg;
      BR_GTZ:  r = !is_neg && !is_zero;
      BR_EQZ:  r = is_zero;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry; a pop from an empty stack leaves state untouched. Both
// report a registered one-cycle flag.
module return_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int PC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_WIDTH-1:0]          push_data,
  output logic [PC_WIDTH-1:0]          top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]       ptr;   // next free slot; wraps naturally (depth is a power of two)

  // Most recent entry sits just below the write pointer.
  assign top_data = mem[ptr - ONE];

  // Entry storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  // Pointer, occupancy and one-cycle error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (push) begin
        ptr <= ptr + ONE;
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + CW'(1);
      end else if (pop) begin
        if (count == '0) begin
          underflow <= 1'b1;
        end else begin
          ptr   <= ptr - ONE;
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC, resolves sign/zero conditional branches,
// call/return through a circular RAS, sticky halt with resume, and stall hold.
// All outputs are registered; decisions land on the next rising edge.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  RAS_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        halt_op,
  input  logic                        resume,
  input  logic [2:0]                  branch_op,
  input  logic [DATA_WIDTH-1:0]       reg2_data,
  input  logic [PC_WIDTH-1:0]         target,
  output logic [PC_WIDTH-1:0]         pc_out,
  output logic                        branch_taken,
  output logic                        halted,
  output logic                        ras_overflow,
  output logic                        ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt, pc_inc, ras_top;
  logic                taken_nxt, push, pop;
  logic                is_neg, is_zero;

  assign pc_inc  = pc_out + PC_WIDTH'(1);
  assign is_neg  = reg2_data[DATA_WIDTH-1];
  assign is_zero = (reg2_data == '0);
  assign halted  = (state == ST_HALTED);

  // Next state, next PC and RAS commands; halt beats stall beats branch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_out;
    taken_nxt = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_RUN: begin
        if (halt_op) begin
          state_nxt = ST_HALTED;
        end else if (!stall) begin
          pc_nxt = pc_inc;
          case (branch_op)
            BR_JMP: begin
              pc_nxt    = target;
              taken_nxt = 1'b1;
            end
            BR_LTZ, BR_GTZ, BR_EQZ: begin
              if (cond_met(branch_op, is_neg, is_zero)) begin
                pc_nxt    = target;
                taken_nxt = 1'b1;
              end
            end
            BR_CALL: begin
              push      = 1'b1;
              pc_nxt    = target;
              taken_nxt = 1'b1;
            end
            BR_RET: begin
              pop = 1'b1;
              // Empty stack falls through to pc+1; the RAS flags the underflow.
              if (ras_count != '0) begin
                pc_nxt    = ras_top;
                taken_nxt = 1'b1;
              end
            end
            default: ;  // BR_NONE and BR_RSVD are sequential
          endcase
        end
      end
      ST_HALTED: begin
        if (resume && !halt_op) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // State, PC and redirect flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      pc_out       <= RESET_PC;
      branch_taken <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_out       <= pc_nxt;
      branch_taken <= taken_nxt;
    end
  end

  return_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule
